// File: rtl/shift_word_collector_if.sv
// Serial-in / word-out bus of the shift word collector.
// The collector uses the slave modport; the upstream stage and consumer use the master modport.
interface shift_word_collector_if #(
  parameter int unsigned WORD_W = 4
);
  logic              sdata;
  logic              sval;
  logic              sof;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              ovf;
  logic [7:0]        word_cnt;

  modport master (
    output sdata, sval, sof, out_ready,
    input  out_data, out_valid, frame_err, ovf, word_cnt
  );

  modport slave (
    input  sdata, sval, sof, out_ready,
    output out_data, out_valid, frame_err, ovf, word_cnt
  );
endinterface

// File: rtl/shift_word_collector.sv
// Reassembles LSB-first serial words from the upstream shift stage into a 2-entry valid/ready buffer,
// flagging early-sof aborts, dropped words and counting accepted words.
module shift_word_collector #(
  parameter int unsigned WORD_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  shift_word_collector_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = 1;
  localparam int unsigned OCC_W = 2;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_nxt;
  logic              push_c;
  logic              abort_c;
  logic [WORD_W-1:0] push_word_c;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_nxt;
  logic              out_valid_q;
  logic              frame_err_q;
  logic              ovf_q;
  logic [7:0]        word_cnt_q;

  logic              pop_c;
  logic              full_c;
  logic              push_ok_c;
  logic              drop_c;

  // Collector state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state: bit assembly, word completion and early-sof abort
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    push_c      = 1'b0;
    abort_c     = 1'b0;
    push_word_c = {bus.sdata, shreg[WORD_W-2:0]};

    case (state)
      IDLE: begin
        if (bus.sval && bus.sof) begin
          shreg_nxt[0] = bus.sdata;
          bit_cnt_nxt  = CNT_W'(1);
          state_nxt    = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.sval) begin
          if (bus.sof) begin
            // Early sof (even on the last bit) restarts with this bit as bit 0
            abort_c      = 1'b1;
            shreg_nxt[0] = bus.sdata;
            bit_cnt_nxt  = CNT_W'(1);
          end else begin
            shreg_nxt[bit_cnt] = bus.sdata;
            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
              push_c      = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = IDLE;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // A full buffer still takes a word if its head leaves on the same edge
  assign pop_c     = out_valid_q && bus.out_ready;
  assign full_c    = (occ == OCC_W'(DEPTH));
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign drop_c    = push_c && !push_ok_c;

  always_comb begin
    occ_nxt = occ;
    case ({push_ok_c, pop_c})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Output buffer and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= push_word_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        word_cnt_q  <= word_cnt_q + 8'd1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ         <= occ_nxt;
      out_valid_q <= (occ_nxt != '0);
      frame_err_q <= abort_c;
      ovf_q       <= ovf_q | drop_c;
    end
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.ovf       = ovf_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_shift_word_collector.sv
// Self-checking bench for shift_word_collector: directed scenarios pinned with literal values,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_shift_word_collector;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;

  shift_word_collector_if #(.WORD_W(W)) bus ();

  shift_word_collector #(.WORD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int ferr_seen;

  // Behavioural model: partial bits so far, buffered words, status
  bit          m_bits [$];
  logic [W-1:0] m_fifo [$];
  bit          m_ferr;
  bit          m_ovf;
  int          m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit           have_word;
    bit           do_pop;
    logic [W-1:0] w;
    if (rst) begin
      m_bits.delete();
      m_fifo.delete();
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      m_ferr    = 1'b0;
      have_word = 1'b0;
      w         = '0;
      do_pop    = (m_fifo.size() > 0) && bus.out_ready;
      if (bus.sval) begin
        if (bus.sof) begin
          if (m_bits.size() > 0) m_ferr = 1'b1;
          m_bits.delete();
          m_bits.push_back(bus.sdata);
        end else if (m_bits.size() > 0) begin
          m_bits.push_back(bus.sdata);
          if (m_bits.size() == W) begin
            for (int i = 0; i < int'(W); i++) w[i] = m_bits[i];
            m_bits.delete();
            have_word = 1'b1;
          end
        end
      end
      if (do_pop) void'(m_fifo.pop_front());
      if (have_word) begin
        if (m_fifo.size() < 2) begin
          m_fifo.push_back(w);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", int'(bus.out_valid), int'(m_fifo.size() != 0));
    chk("frame_err", int'(bus.frame_err), int'(m_ferr));
    chk("ovf", int'(bus.ovf), int'(m_ovf));
    chk("word_cnt", int'(bus.word_cnt), m_cnt);
    if (m_fifo.size() != 0) chk("out_data", int'(bus.out_data), int'(m_fifo[0]));
    if (bus.frame_err) ferr_seen++;
  endtask

  // One clock: inputs already driven, advance model on the edge, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sdata     = 1'($urandom);
      bus.sval      = 1'($urandom);
      bus.sof       = 1'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
    end
    rst           = 1'b0;
    bus.sdata     = 1'b0;
    bus.sval      = 1'b0;
    bus.sof       = 1'b0;
    bus.out_ready = 1'b0;
    ferr_seen     = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit ready_last);
    for (int i = 0; i < int'(W); i++) begin
      bus.sdata = w[i];
      bus.sval  = 1'b1;
      bus.sof   = (i == 0);
      if (i == int'(W) - 1 && ready_last) bus.out_ready = 1'b1;
      tick();
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.sval = 1'b0;
          bus.sof  = 1'b0;
          tick();
        end
      end
    end
    bus.sval = 1'b0;
    bus.sof  = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    ferr_seen     = 0;
    rst           = 1'b1;
    bus.sdata     = 1'b0;
    bus.sval      = 1'b0;
    bus.sof       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset with random inputs
    do_reset();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_word_cnt", int'(bus.word_cnt), 0);

    // Single word 1011, bits 1,1,0,1
    send_word(4'b1011, 0, 1'b0);
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_data", int'(bus.out_data), 'hB);
    chk("single_cnt", int'(bus.word_cnt), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("single_pop_valid", int'(bus.out_valid), 0);

    // Stream with 2-cycle gaps between bits 1 and 2
    do_reset();
    bus.out_ready = 1'b1;
    send_word(4'h5, 2, 1'b0);
    chk("gap_data0", int'(bus.out_data), 'h5);
    send_word(4'hA, 2, 1'b0);
    chk("gap_data1", int'(bus.out_data), 'hA);
    chk("gap_cnt", int'(bus.word_cnt), 2);
    chk("gap_no_ferr", ferr_seen, 0);

    // Framing error: partial 1,0 then sof with 4'hC
    do_reset();
    bus.sdata = 1'b1; bus.sval = 1'b1; bus.sof = 1'b1;
    tick();
    bus.sdata = 1'b0; bus.sof = 1'b0;
    tick();
    send_word(4'hC, 0, 1'b0);
    chk("ferr_pulses", ferr_seen, 1);
    chk("ferr_cnt", int'(bus.word_cnt), 1);
    chk("ferr_data", int'(bus.out_data), 'hC);

    // Overflow: three words into a 2-entry buffer
    do_reset();
    send_word(4'h1, 0, 1'b0);
    send_word(4'h2, 0, 1'b0);
    send_word(4'h3, 0, 1'b0);
    chk("ovf_set", int'(bus.ovf), 1);
    chk("ovf_cnt", int'(bus.word_cnt), 2);
    chk("ovf_head0", int'(bus.out_data), 'h1);
    bus.out_ready = 1'b1;
    tick();
    chk("ovf_head1", int'(bus.out_data), 'h2);
    tick();
    chk("ovf_empty", int'(bus.out_valid), 0);
    chk("ovf_sticky", int'(bus.ovf), 1);

    // Full buffer with pop on the same edge as the last bit
    do_reset();
    send_word(4'h1, 0, 1'b0);
    send_word(4'h2, 0, 1'b0);
    send_word(4'h3, 0, 1'b1);
    chk("fullpop_ovf", int'(bus.ovf), 0);
    chk("fullpop_cnt", int'(bus.word_cnt), 3);
    chk("fullpop_head1", int'(bus.out_data), 'h2);
    tick();
    chk("fullpop_head2", int'(bus.out_data), 'h3);
    tick();
    chk("fullpop_empty", int'(bus.out_valid), 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      bus.sval      = ($urandom_range(0, 99) < 75);
      bus.sdata     = 1'($urandom);
      bus.sof       = (m_bits.size() == 0) ? ($urandom_range(0, 99) < 60)
                                           : ($urandom_range(0, 99) < 6);
      bus.out_ready = ($urandom_range(0, 99) < 55);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
